// File: rtl/alu_pkg.sv
// Opcode constants, opcode classification helpers and the sequencer state
// encoding shared by the ALU operation sequencer and its neighbours.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_MUL  = 5'b00011;
    localparam logic [4:0] OP_DIV  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_SHRA = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_NEG  = 5'b01100;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_NOR  = 5'b01110;
    localparam logic [4:0] OP_NOT  = 5'b01111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_Y,
        ST_RD_B,
        ST_EXEC,
        ST_WB,
        ST_ERR
    } seq_state_t;

    // mul/div run on the long ALU path and write back to HI/LO.
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal_op(input logic [4:0] op);
        return (op != 5'b00000) && !op[4];
    endfunction

endpackage

// File: rtl/op_latency_counter.sv
// Down-counter used to time the ALU result latency; flags when it reaches zero.
module op_latency_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ra = rb op rc request: two register reads, ALU wait,
// then writeback to ra or to HI/LO.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int ALU_LAT    = 1,
    parameter int MULDIV_LAT = 32
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4:0]             req_opcode,
    input  logic [3:0]             req_ra,
    input  logic [3:0]             req_rb,
    input  logic [3:0]             req_rc,
    output logic [3:0]             rf_rd_addr,
    input  logic [WORD_SIZE-1:0]   rf_rd_data,
    output logic [WORD_SIZE-1:0]   alu_y,
    output logic [WORD_SIZE-1:0]   alu_a,
    output logic [WORD_SIZE-1:0]   alu_b,
    output logic [4:0]             alu_opcode,
    input  logic [2*WORD_SIZE-1:0] alu_c,
    output logic                   wb_valid,
    output logic [3:0]             wb_addr,
    output logic [WORD_SIZE-1:0]   wb_data,
    output logic                   hi_we,
    output logic                   lo_we,
    output logic [WORD_SIZE-1:0]   hi_data,
    output logic [WORD_SIZE-1:0]   lo_data,
    output logic                   done,
    output logic                   err
);

    localparam int MAX_LAT = (ALU_LAT > MULDIV_LAT) ? ALU_LAT : MULDIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    seq_state_t             r_state;
    seq_state_t             w_next;
    logic [4:0]             r_opcode;
    logic [3:0]             r_ra;
    logic [3:0]             r_rb;
    logic [3:0]             r_rc;
    logic [WORD_SIZE-1:0]   r_alu_y;
    logic [WORD_SIZE-1:0]   r_alu_b;
    logic [4:0]             r_alu_opcode;
    logic [2*WORD_SIZE-1:0] r_z;
    logic                   w_cnt_load;
    logic                   w_cnt_dec;
    logic                   w_cnt_zero;
    logic [CNT_W-1:0]       w_cnt_val;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next = is_legal_op(req_opcode) ? ST_RD_Y : ST_ERR;
            ST_RD_Y: w_next = ST_RD_B;
            ST_RD_B: w_next = ST_EXEC;
            ST_EXEC: if (w_cnt_zero) w_next = ST_WB;
            ST_WB:   w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // The counter is loaded with L-1 so the result is captured on the L-th EXEC edge.
    assign w_cnt_load = (r_state == ST_RD_B);
    assign w_cnt_dec  = (r_state == ST_EXEC) && !w_cnt_zero;
    assign w_cnt_val  = is_muldiv(r_opcode) ? CNT_W'(MULDIV_LAT - 1) : CNT_W'(ALU_LAT - 1);

    op_latency_counter #(.CNT_W(CNT_W)) u_lat_cnt (
        .clk        (clk),
        .clr        (clr),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_opcode     <= '0;
            r_ra         <= '0;
            r_rb         <= '0;
            r_rc         <= '0;
            r_alu_y      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_z          <= '0;
        end else begin
            if (r_state == ST_IDLE && req_valid) begin
                r_opcode <= req_opcode;
                r_ra     <= req_ra;
                r_rb     <= req_rb;
                r_rc     <= req_rc;
            end
            if (r_state == ST_RD_Y) r_alu_y <= rf_rd_data;
            if (r_state == ST_RD_B) begin
                r_alu_b      <= rf_rd_data;
                r_alu_opcode <= r_opcode;
            end
            if (r_state == ST_EXEC && w_cnt_zero) r_z <= alu_c;
        end
    end

    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        rf_rd_addr = 4'd0;
        wb_valid   = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (r_state)
            ST_RD_Y: rf_rd_addr = r_rb;
            ST_RD_B: rf_rd_addr = r_rc;
            ST_WB: begin
                done     = 1'b1;
                wb_valid = !is_muldiv(r_opcode);
                hi_we    = is_muldiv(r_opcode);
                lo_we    = is_muldiv(r_opcode);
            end
            ST_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_y      = r_alu_y;
    assign alu_a      = r_alu_y;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_opcode;
    assign wb_addr    = r_ra;
    assign wb_data    = r_z[WORD_SIZE-1:0];
    assign hi_data    = r_z[2*WORD_SIZE-1:WORD_SIZE];
    assign lo_data    = r_z[WORD_SIZE-1:0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural register file and a
// latency-accurate ALU model.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int W          = 32;
    localparam int ALU_LAT    = 1;
    localparam int MULDIV_LAT = 32;

    logic           clk = 1'b0;
    logic           clr;
    logic           req_valid;
    logic           req_ready;
    logic [4:0]     req_opcode;
    logic [3:0]     req_ra, req_rb, req_rc;
    logic [3:0]     rf_rd_addr;
    logic [W-1:0]   rf_rd_data;
    logic [W-1:0]   alu_y, alu_a, alu_b;
    logic [4:0]     alu_opcode;
    logic [2*W-1:0] alu_c;
    logic           wb_valid;
    logic [3:0]     wb_addr;
    logic [W-1:0]   wb_data;
    logic           hi_we, lo_we;
    logic [W-1:0]   hi_data, lo_data;
    logic           done, err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WORD_SIZE(W), .ALU_LAT(ALU_LAT), .MULDIV_LAT(MULDIV_LAT)) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_ra(req_ra), .req_rb(req_rb), .req_rc(req_rc),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .alu_y(alu_y), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_c(alu_c),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .hi_we(hi_we), .lo_we(lo_we), .hi_data(hi_data), .lo_data(lo_data),
        .done(done), .err(err)
    );

    // Register file: combinational read.
    logic [W-1:0] rf [16];
    assign rf_rd_data = rf[rf_rd_addr];

    // ALU model: result only valid once operands/opcode have been stable for the latency.
    logic [2*W-1:0] alu_res;
    logic [2*W+4:0] snap;
    int             stable_cnt = 0;
    logic           changed;
    int             age;
    int             lat;

    always_comb begin
        alu_res = '0;
        case (alu_opcode)
            OP_ADD: alu_res = {32'd0, alu_a + alu_b};
            OP_SUB: alu_res = {32'd0, alu_a - alu_b};
            OP_MUL: alu_res = {32'd0, alu_a} * {32'd0, alu_b};
            OP_DIV: alu_res = (alu_b == 0) ? '0 : {alu_a % alu_b, alu_a / alu_b};
            OP_AND: alu_res = {32'd0, alu_a & alu_b};
            OP_OR:  alu_res = {32'd0, alu_a | alu_b};
            OP_XOR: alu_res = {32'd0, alu_a ^ alu_b};
            default: alu_res = '0;
        endcase
    end

    assign changed = ({alu_y, alu_b, alu_opcode} !== snap);
    assign age     = changed ? 0 : stable_cnt;
    assign lat     = is_muldiv(alu_opcode) ? MULDIV_LAT : ALU_LAT;
    assign alu_c   = (age + 1 >= lat) ? alu_res : {2*W{1'b0}};

    always @(posedge clk) begin
        snap       <= {alu_y, alu_b, alu_opcode};
        stable_cnt <= changed ? 1 : stable_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [4:0] op, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [3:0] rc);
        req_valid  = 1'b1;
        req_opcode = op;
        req_ra     = ra;
        req_rb     = rb;
        req_rc     = rc;
    endtask

    int cyc;
    int strobes;

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h0;
        rf[2] = 32'd5;
        rf[3] = 32'd7;
        rf[4] = 32'h0001_0000;
        rf[5] = 32'h0001_0000;
        rf[6] = 32'hFFFF_FFF0;

        clr = 1'b1;
        req_valid = 1'b0;
        req_opcode = '0;
        req_ra = '0;
        req_rb = '0;
        req_rc = '0;
        repeat (3) step();
        clr = 1'b0;
        step();
        check("rst_ready", req_ready, 1);
        check("rst_alu_y", alu_y, 0);
        check("rst_rdaddr", rf_rd_addr, 0);
        check("rst_strobes", {done, err, wb_valid, hi_we, lo_we}, 0);

        // add R1 = R2 + R3
        request(OP_ADD, 4'd1, 4'd2, 4'd3);
        check("add_ready_c0", req_ready, 1);
        step();
        req_valid = 1'b0;
        check("add_rd_rb", rf_rd_addr, 2);
        step();
        check("add_rd_rc", rf_rd_addr, 3);
        check("add_alu_y", alu_y, 5);
        step();
        check("add_alu_a", alu_a, 5);
        check("add_alu_b", alu_b, 7);
        check("add_alu_op", alu_opcode, OP_ADD);
        check("add_no_done_c3", done, 0);
        step();
        check("add_done_c4", {done, wb_valid, err, hi_we, lo_we}, 5'b11000);
        check("add_wb_addr", wb_addr, 1);
        check("add_wb_data", wb_data, 12);
        step();
        check("add_idle_c5", {req_ready, done, rf_rd_addr}, {1'b1, 1'b0, 4'd0});

        // mul R4 * R5, done expected at cycle 35
        request(OP_MUL, 4'd0, 4'd4, 4'd5);
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            req_valid = 1'b0;
            cyc++;
            if (done) break;
        end
        check("mul_done_cycle", cyc, 35);
        check("mul_strobes", {hi_we, lo_we, wb_valid, err}, 4'b1100);
        check("mul_hi", hi_data, 32'h1);
        check("mul_lo", lo_data, 32'h0);
        step();

        // illegal opcode
        request(5'b10000, 4'd1, 4'd2, 4'd3);
        step();
        req_valid = 1'b0;
        check("ill_done_err", {done, err}, 2'b11);
        check("ill_rdaddr", rf_rd_addr, 0);
        check("ill_no_wr", {wb_valid, hi_we, lo_we}, 0);
        step();
        check("ill_back_idle", {req_ready, done, err}, 3'b100);

        // div abandoned by clr in cycle 10
        request(OP_DIV, 4'd1, 4'd6, 4'd2);
        for (int i = 0; i < 10; i++) begin
            step();
            req_valid = 1'b0;
        end
        check("div_busy_c10", req_ready, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_ready_c11", req_ready, 1);
        check("clr_alu_zero", {alu_y, alu_b, alu_opcode}, 0);
        check("clr_data_zero", {hi_data, lo_data}, 0);
        check("clr_wb_zero", {wb_addr, wb_data}, 0);
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || wb_valid || hi_we || lo_we || err) strobes++;
            step();
        end
        check("clr_no_strobes", strobes, 0);

        // back-to-back: xor then or, req_valid held high
        request(OP_XOR, 4'd8, 4'd2, 4'd3);
        step();
        req_opcode = OP_OR;
        req_ra     = 4'd9;
        step();
        step();
        step();
        check("b2b_first_done", {done, wb_valid, req_ready}, 3'b110);
        check("b2b_first_addr", wb_addr, 8);
        check("b2b_first_data", wb_data, 2);
        step();
        check("b2b_accept_c5", req_ready, 1);
        step();
        req_valid = 1'b0;
        check("b2b_second_busy", req_ready, 0);
        step();
        step();
        step();
        check("b2b_second_done", {done, wb_valid}, 2'b11);
        check("b2b_second_addr", wb_addr, 9);
        check("b2b_second_data", wb_data, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
